calcula_pontuacao: RTL and testbench
====================================

Name: calcula_pontuacao

Overview:
- Score-calculation client for the board memory controller: the reading side of the controller's pontuacao read port.
- On a start pulse it requests memory access for one player and sweeps rows 0..ROWS-1, one row at a time.
- For each row it counts hit cells and accumulates them into a score, then reports the total with a one-cycle done pulse.
- Sits beside the colisor, validador and VGA clients; it never writes memory.

Parameters:
- ROWS, 12, number of board rows swept (addresses 0..ROWS-1), range 1..32.
- READ_LAT, 1, clocks from address presented with grant high to the row word being valid on data_in; range 1..3.
- SCORE_W, 9, score width; must hold ROWS*32.

Ports:
- clk  in  1  system clock.
- resetGeral  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to compute the score of player jogador_in.
- jogador_in  in  1  0 = player one, 1 = player two; sampled on accepted start.
- grant  in  1  high while the controller is serving this client; addr is routed to memory only then.
- data_in  in  64  row word returned by the controller for the selected player.
- req  out  1  access request to the controller (readyCalculaPontuacao).
- addr  out  5  row address (pontuacao_readaddr).
- jogador  out  1  player selection held for the whole sweep (jogadorPontuacao).
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse when score is final.
- score  out  SCORE_W  accumulated hit count; held until the next accepted start.

Behaviour:
- Reset (async, resetGeral=0) sets: req=0, addr=0, jogador=0, busy=0, done=0, score=0, state IDLE, wait counter 0. Reset mid-sweep aborts the sweep with no done pulse.
- Row format: 32 cells of 2 bits each; cell k occupies bits [2k+1:2k]. Encoding: 00 water, 01 ship, 10 miss, 11 hit.
- Row hit count: number of cells equal to 11, giving 0..32 (6 bits). It is zero-extended before being added to score.
- States:
  - IDLE: on start, clear score, latch jogador_in into jogador, set addr=0, busy=1, go to REQ. Otherwise ignore inputs.
  - REQ: req=1. When grant=1, load the wait counter with READ_LAT and go to WAIT.
  - WAIT: req=1, addr held. Decrement each cycle while grant=1. If grant falls, return to REQ and reissue the same row (the data is discarded). At count 1 with grant=1, go to ACC.
  - ACC: sample data_in, add the row hit count to score. If addr==ROWS-1, go to DONE. Otherwise addr+1 and go to REQ.
  - DONE: req=0, busy=0, done=1 for exactly one cycle, then IDLE.
- Per-row latency with continuous grant: 1 (REQ) + READ_LAT (WAIT) + 1 (ACC) cycles. With the defaults, one sweep takes 12*3 cycles plus 1 (DONE) = 37 cycles from start to done.
- req stays high across row boundaries except in ACC, where it drops for one cycle. This lets the arbiter rotate to the VGA client.
- A start while busy=1 is ignored; the sweep in progress is unaffected.
- A start in the same cycle as done is ignored (the FSM is in DONE). A start one cycle later is accepted.
- Arithmetic: score never wraps because SCORE_W >= log2(ROWS*32+1). addr never exceeds ROWS-1.
- grant while req=0 is ignored.

Optional Feature:
- Macro: CALCULA_PONTUACAO_NAVIOS_EN.
- Defined:
  - Adds output navios_restantes (SCORE_W), counting cells equal to 01, accumulated in ACC alongside score.
  - Adds output derrota (1), valid with done: 1 when navios_restantes==0, i.e. all ships of that player are sunk.
  - Both outputs reset to 0 and are cleared on accepted start.
- Undefined: the ports and counters do not exist. Score behaviour is identical in both builds.

Decomposition:
- Shared package batalha_pkg holds:
  - cell encoding constants CELULA_AGUA, CELULA_NAVIO, CELULA_ERRO, CELULA_ACERTO;
  - ROW_W=64, CELLS_PER_ROW=32, ADDR_W=5;
  - the state enumeration type for this FSM.
- Sub-module contador_celulas_linha: purely combinational. Inputs are a 64-bit row and a 2-bit target cell code; output is a 6-bit count. It is instantiated once for hits, and once more for ships when the macro is defined.

Test Plan:
- Reset then idle: no start -> req=0, busy=0, score=0 indefinitely; async reset asserted between clock edges clears outputs immediately.
- Full sweep, grant tied 1, each row 64'hFFFF_FFFF_FFFF_FFFF (32 hits) -> addr steps 0..11, done exactly 37 cycles after start, score=384.
- Mixed board: row 0 = 64'h0000_0000_0000_0003 (1 hit), row 5 = 64'hC000_0000_0000_000F (3 hits), other rows 0 -> score=4, jogador held at the latched value (start with jogador_in=1, toggle jogador_in afterwards -> jogador stays 1).
- Grant drop: deassert grant in the WAIT cycle of row 3 for 4 cycles -> addr stays 3, row 3 counted once, final score unchanged versus uninterrupted run, done delayed by 5 cycles.
- Start while busy: second start pulse at cycle 10 of a sweep -> ignored, a single done pulse, score from the first sweep only. Reset asserted at cycle 20 -> no done, all outputs 0.
- With CALCULA_PONTUACAO_NAVIOS_EN: board with one 01 cell at row 2 -> navios_restantes=1, derrota=0. All ship cells changed to 11 -> navios_restantes=0, derrota=1 at done.

Source files
------------

// File: rtl/batalha_pkg.sv
// rtl/batalha_pkg.sv - shared board constants, cell encodings and score FSM states
package batalha_pkg;

  localparam int ROW_W         = 64;
  localparam int CELLS_PER_ROW = 32;
  localparam int ADDR_W        = 5;

  localparam logic [1:0] CELULA_AGUA   = 2'b00;
  localparam logic [1:0] CELULA_NAVIO  = 2'b01;
  localparam logic [1:0] CELULA_ERRO   = 2'b10;
  localparam logic [1:0] CELULA_ACERTO = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_ACC,
    ST_DONE
  } pontuacao_state_t;

endpackage

// File: rtl/contador_celulas_linha.sv
// rtl/contador_celulas_linha.sv - combinational count of cells in a row matching a target code
module contador_celulas_linha
  import batalha_pkg::*;
(
  input  logic [ROW_W-1:0] row,
  input  logic [1:0]       target,
  output logic [5:0]       count
);

  always_comb begin
    count = '0;
    for (int k = 0; k < CELLS_PER_ROW; k++) begin
      if (row[2*k +: 2] == target) begin
        count = count + 6'd1;
      end
    end
  end

endmodule

// File: rtl/calcula_pontuacao.sv
// rtl/calcula_pontuacao.sv - row-sweeping hit counter for one player; CALCULA_PONTUACAO_NAVIOS_EN adds ship count
module calcula_pontuacao
  import batalha_pkg::*;
#(
  parameter int ROWS     = 12,
  parameter int READ_LAT = 1,
  parameter int SCORE_W  = 9
) (
  input  logic               clk,
  input  logic               resetGeral,
  input  logic               start,
  input  logic               jogador_in,
  input  logic               grant,
  input  logic [ROW_W-1:0]   data_in,
  output logic               req,
  output logic [ADDR_W-1:0]  addr,
  output logic               jogador,
  output logic               busy,
  output logic               done,
  output logic [SCORE_W-1:0] score
`ifdef CALCULA_PONTUACAO_NAVIOS_EN
  ,
  output logic [SCORE_W-1:0] navios_restantes,
  output logic               derrota
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);
  localparam logic [1:0]        LAT_LOAD = 2'(READ_LAT);

  pontuacao_state_t state_q, state_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_d;
  logic               jogador_d;
  logic [SCORE_W-1:0] score_d;
  logic [5:0]         hits;

  contador_celulas_linha u_hits (
    .row    (data_in),
    .target (CELULA_ACERTO),
    .count  (hits)
  );

`ifdef CALCULA_PONTUACAO_NAVIOS_EN
  logic [5:0]         ships;
  logic [SCORE_W-1:0] navios_d;
  logic               derrota_d;

  contador_celulas_linha u_ships (
    .row    (data_in),
    .target (CELULA_NAVIO),
    .count  (ships)
  );
`endif

  always_ff @(posedge clk or negedge resetGeral) begin
    if (!resetGeral) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr    <= '0;
      jogador <= 1'b0;
      score   <= '0;
`ifdef CALCULA_PONTUACAO_NAVIOS_EN
      navios_restantes <= '0;
      derrota          <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr    <= addr_d;
      jogador <= jogador_d;
      score   <= score_d;
`ifdef CALCULA_PONTUACAO_NAVIOS_EN
      navios_restantes <= navios_d;
      derrota          <= derrota_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr;
    jogador_d = jogador;
    score_d   = score;
    req       = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
`ifdef CALCULA_PONTUACAO_NAVIOS_EN
    navios_d  = navios_restantes;
    derrota_d = derrota;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          score_d   = '0;
          jogador_d = jogador_in;
          addr_d    = '0;
          state_d   = ST_REQ;
`ifdef CALCULA_PONTUACAO_NAVIOS_EN
          navios_d  = '0;
          derrota_d = 1'b0;
`endif
        end
      end
      ST_REQ: begin
        req  = 1'b1;
        busy = 1'b1;
        if (grant) begin
          cnt_d   = LAT_LOAD;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Losing grant mid-read invalidates the row; reissue the same address.
        req  = 1'b1;
        busy = 1'b1;
        if (!grant) begin
          state_d = ST_REQ;
        end else if (cnt_q == 2'd1) begin
          state_d = ST_ACC;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ST_ACC: begin
        busy    = 1'b1;
        score_d = score + SCORE_W'(hits);
`ifdef CALCULA_PONTUACAO_NAVIOS_EN
        navios_d = navios_restantes + SCORE_W'(ships);
`endif
        if (addr == LAST_ROW) begin
          state_d = ST_DONE;
`ifdef CALCULA_PONTUACAO_NAVIOS_EN
          derrota_d = (navios_d == '0);
`endif
        end else begin
          addr_d  = addr + 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_calcula_pontuacao.sv
// tb/tb_calcula_pontuacao.sv - scoreboard bench for calcula_pontuacao
module tb_calcula_pontuacao;
  logic        clk;
  logic        resetGeral;
  logic        start;
  logic        jogador_in;
  logic        grant;
  logic [63:0] data_in;
  logic        req;
  logic [4:0]  addr;
  logic        jogador;
  logic        busy;
  logic        done;
  logic [8:0]  score;
`ifdef CALCULA_PONTUACAO_NAVIOS_EN
  logic [8:0]  navios_restantes;
  logic        derrota;
`endif

  calcula_pontuacao dut (
    .clk        (clk),
    .resetGeral (resetGeral),
    .start      (start),
    .jogador_in (jogador_in),
    .grant      (grant),
    .data_in    (data_in),
    .req        (req),
    .addr       (addr),
    .jogador    (jogador),
    .busy       (busy),
    .done       (done),
    .score      (score)
`ifdef CALCULA_PONTUACAO_NAVIOS_EN
    ,
    .navios_restantes (navios_restantes),
    .derrota          (derrota)
`endif
  );

  typedef struct {
    logic [8:0] score;
    logic       jog;
    int         done_cyc;
    logic [8:0] nav;
    logic       der;
  } exp_t;

  exp_t        sbq[$];
  logic [63:0] mem [2][12];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic        prev_done = 1'b0;
  logic        prev_busy = 1'b0;
  logic [4:0]  prev_addr = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // One-cycle registered read port, only fed while grant is high.
  always @(posedge clk) data_in <= grant ? mem[jogador ? 1 : 0][int'(addr)] : 64'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (resetGeral) begin
      if (done) begin
        check("done_width", 32'(prev_done), 32'd0);
        if (sbq.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          check("score", 32'(score), 32'(e.score));
          check("jogador", 32'(jogador), 32'(e.jog));
          check("done_cycle", 32'(cyc), 32'(e.done_cyc));
          check("final_addr", 32'(addr), 32'd11);
          check("busy_at_done", 32'(busy), 32'd0);
          check("req_at_done", 32'(req), 32'd0);
`ifdef CALCULA_PONTUACAO_NAVIOS_EN
          check("navios", 32'(navios_restantes), 32'(e.nav));
          check("derrota", 32'(derrota), 32'(e.der));
`endif
        end
      end
      if (busy && prev_busy && addr != prev_addr)
        check("addr_step", 32'(addr), 32'(prev_addr) + 32'd1);
    end
    prev_done = done;
    prev_busy = busy;
    prev_addr = addr;
  end

  // Called at a negedge; start is held for exactly one cycle.
  task automatic issue_start(input logic jog, input logic [8:0] sc, input int lat,
                             input logic [8:0] nav, input logic der);
    exp_t e;
    start      = 1'b1;
    jogador_in = jog;
    e.score    = sc;
    e.jog      = jog;
    e.done_cyc = cyc + lat;
    e.nav      = nav;
    e.der      = der;
    sbq.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) return;
    end
    check("done_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    resetGeral = 1'b0;
    start      = 1'b0;
    jogador_in = 1'b0;
    grant      = 1'b1;
    for (int r = 0; r < 12; r++) begin
      mem[0][r] = 64'hFFFF_FFFF_FFFF_FFFF;
      mem[1][r] = 64'h0;
    end
    mem[1][0] = 64'h0000_0000_0000_0003;
    mem[1][2] = 64'h0000_0000_0000_0001;
    mem[1][5] = 64'hC000_0000_0000_000F;

    repeat (3) @(negedge clk);
    check("rst_req", 32'(req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_score", 32'(score), 32'd0);
    check("rst_addr", 32'(addr), 32'd0);
    resetGeral = 1'b1;
    repeat (6) @(negedge clk);
    check("idle_req", 32'(req), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_score", 32'(score), 32'd0);

    // Full board of hits, continuous grant.
    issue_start(1'b0, 9'd384, 37, 9'd0, 1'b1);
    wait_done();
    // Start coinciding with done is dropped.
    start      = 1'b1;
    jogador_in = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_on_done_ignored", 32'(busy), 32'd0);

    // Mixed board; start accepted one cycle after done; jogador latched.
    issue_start(1'b1, 9'd4, 37, 9'd1, 1'b0);
    jogador_in = 1'b0;
    repeat (5) @(negedge clk);
    check("jogador_held", 32'(jogador), 32'd1);
    check("busy_mid", 32'(busy), 32'd1);
    wait_done();

    // Grant drops during row 3 read for 4 cycles.
    @(negedge clk);
    issue_start(1'b0, 9'd384, 42, 9'd0, 1'b1);
    for (int i = 0; i < 60 && !(req && addr == 5'd3); i++) @(negedge clk);
    check("row3_reached", 32'(addr), 32'd3);
    @(posedge clk);
    #1 grant = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("addr_hold", 32'(addr), 32'd3);
      @(posedge clk);
    end
    #1 grant = 1'b1;
    wait_done();

    // Second start mid-sweep is ignored.
    @(negedge clk);
    issue_start(1'b1, 9'd4, 37, 9'd1, 1'b0);
    repeat (8) @(negedge clk);
    start      = 1'b1;
    jogador_in = 1'b0;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // Asynchronous reset mid-sweep aborts without done.
    @(negedge clk);
    issue_start(1'b1, 9'd4, 37, 9'd1, 1'b0);
    repeat (19) @(negedge clk);
    #2 resetGeral = 1'b0;
    #1;
    check("abort_score", 32'(score), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_req", 32'(req), 32'd0);
    check("abort_jogador", 32'(jogador), 32'd0);
    check("abort_addr", 32'(addr), 32'd0);
    sbq.delete();
    repeat (3) @(negedge clk);
    resetGeral = 1'b1;
    repeat (40) @(negedge clk);
    check("post_abort_idle", 32'(busy), 32'd0);

    // Recovery sweep after reset.
    issue_start(1'b1, 9'd4, 37, 9'd1, 1'b0);
    wait_done();
    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sbq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
